// File: rtl/ball_engine.sv
// Ball position engine for the 8x8 pong field: serve / rally / miss sequencing,
// wall reflection, paddle bounces from the registered hit_vec, and miss pulses.
// Optional feature macro: BALL_SPEEDUP_EN (tick divider plus rally-hit speed-up).
module ball_engine #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned BIT_OF_WIDTH = 3,
  parameter int unsigned X_MIN        = 1,
  parameter int unsigned X_MAX        = 6,
  parameter int unsigned SERVE_X      = 3,
  parameter int unsigned SERVE_Y      = 3,
  parameter int unsigned MISS_TICKS   = 4,
  parameter int unsigned SLOW_DIV     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    start,
  input  logic [7:0]              hit_vec,
  output logic [BIT_OF_WIDTH-1:0] x_pos,
  output logic [BIT_OF_WIDTH-1:0] y_pos,
  output logic                    dir_x,
  output logic                    dir_y,
  output logic                    top_miss,
  output logic                    down_miss,
  output logic                    busy
);

  localparam int unsigned BW    = BIT_OF_WIDTH;
  localparam int unsigned CNT_W = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;

  localparam logic [BW-1:0] X_LO         = BW'(X_MIN);
  localparam logic [BW-1:0] X_HI         = BW'(X_MAX);
  localparam logic [BW-1:0] SX           = BW'(SERVE_X);
  localparam logic [BW-1:0] SY           = BW'(SERVE_Y);
  localparam logic [BW-1:0] ROW_TOP_GOAL = BW'(0);
  localparam logic [BW-1:0] ROW_TOP_PAD  = BW'(1);
  localparam logic [BW-1:0] ROW_BOT_PAD  = BW'(WIDTH - 2);
  localparam logic [BW-1:0] ROW_BOT_GOAL = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_TICKS - 1);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_RUN   = 2'd1,
    ST_MISS  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     x_nxt, y_nxt;
  logic              dx_nxt, dy_nxt, top_nxt, down_nxt, busy_nxt;
  logic [CNT_W-1:0]  miss_cnt, miss_cnt_nxt;
  logic              hdir;
  logic              move_c;
  logic              top_hit_c, bot_hit_c, at_top_c, at_bot_c;
  logic              unused_hit_bits;

  // One horizontal step with wall reflection; returns {new_dir, new_x}.
  function automatic logic [BW:0] h_step(input logic [BW-1:0] x, input logic dir);
    logic [BW:0] r;
    if (dir) begin
      r = (x >= X_HI) ? {1'b0, x - BW'(1)} : {1'b1, x + BW'(1)};
    end else begin
      r = (x <= X_LO) ? {1'b1, x + BW'(1)} : {1'b0, x - BW'(1)};
    end
    return r;
  endfunction

  // Paddle contact decode: centre cell or the corner cell ahead of the ball.
  assign top_hit_c = hit_vec[1] | (dir_x & hit_vec[2]) | (~dir_x & hit_vec[0]);
  assign bot_hit_c = hit_vec[6] | (dir_x & hit_vec[7]) | (~dir_x & hit_vec[5]);
  assign at_top_c  = ~dir_y && (y_pos == ROW_TOP_PAD);
  assign at_bot_c  = dir_y && (y_pos == ROW_BOT_PAD);
  assign unused_hit_bits = ^hit_vec[4:3];

`ifdef BALL_SPEEDUP_EN
  localparam int unsigned DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [2:0] HIT_SAT = 3'd4;

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [2:0]       hit_cnt, hit_nxt;

  // Move enable: every SLOW_DIV-th tick until the rally reaches HIT_SAT hits.
  always_comb begin
    div_nxt = div_cnt;
    hit_nxt = hit_cnt;
    move_c  = 1'b0;
    if (state == ST_SERVE) begin
      div_nxt = '0;
      hit_nxt = '0;
    end else if (state == ST_RUN && tick) begin
      if (hit_cnt == HIT_SAT) begin
        move_c = 1'b1;
      end else if (div_cnt == DIV_LAST) begin
        move_c  = 1'b1;
        div_nxt = '0;
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
      if (move_c && hit_cnt != HIT_SAT &&
          ((at_top_c && top_hit_c) || (at_bot_c && bot_hit_c))) begin
        hit_nxt = hit_cnt + 3'd1;
      end
    end
  end

  // Speed-up state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      hit_cnt <= '0;
    end else begin
      div_cnt <= div_nxt;
      hit_cnt <= hit_nxt;
    end
  end
`else
  localparam int unsigned unused_slow_div = SLOW_DIV;

  // Without speed-up every tick moves the ball.
  assign move_c = tick;
`endif

  // Next-state and next-output logic for the serve / rally / miss sequence.
  always_comb begin
    state_nxt    = state;
    x_nxt        = x_pos;
    y_nxt        = y_pos;
    dx_nxt       = dir_x;
    dy_nxt       = dir_y;
    top_nxt      = 1'b0;
    down_nxt     = 1'b0;
    miss_cnt_nxt = miss_cnt;
    hdir         = dir_x;
    unique case (state)
      ST_SERVE: begin
        x_nxt        = SX;
        y_nxt        = SY;
        miss_cnt_nxt = '0;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (move_c) begin
          y_nxt = dir_y ? (y_pos + BW'(1)) : (y_pos - BW'(1));
          if (at_top_c) begin
            if (top_hit_c) begin
              dy_nxt = 1'b1;
              y_nxt  = ROW_TOP_PAD + BW'(1);
              if (!hit_vec[1]) hdir = ~dir_x;
            end else begin
              y_nxt     = ROW_TOP_GOAL;
              top_nxt   = 1'b1;
              state_nxt = ST_MISS;
            end
          end else if (at_bot_c) begin
            if (bot_hit_c) begin
              dy_nxt = 1'b0;
              y_nxt  = ROW_BOT_PAD - BW'(1);
              if (!hit_vec[6]) hdir = ~dir_x;
            end else begin
              y_nxt     = ROW_BOT_GOAL;
              down_nxt  = 1'b1;
              state_nxt = ST_MISS;
            end
          end
          {dx_nxt, x_nxt} = h_step(x_pos, hdir);
        end
      end
      ST_MISS: begin
        if (tick) begin
          if (miss_cnt == MISS_LAST) begin
            state_nxt    = ST_SERVE;
            x_nxt        = SX;
            y_nxt        = SY;
            dy_nxt       = (y_pos == ROW_BOT_GOAL);
            miss_cnt_nxt = '0;
          end else begin
            miss_cnt_nxt = miss_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_SERVE;
    endcase
    busy_nxt = (state_nxt != ST_SERVE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SERVE;
      x_pos     <= SX;
      y_pos     <= SY;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      top_miss  <= 1'b0;
      down_miss <= 1'b0;
      busy      <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      x_pos     <= x_nxt;
      y_pos     <= y_nxt;
      dir_x     <= dx_nxt;
      dir_y     <= dy_nxt;
      top_miss  <= top_nxt;
      down_miss <= down_nxt;
      busy      <= busy_nxt;
      miss_cnt  <= miss_cnt_nxt;
    end
  end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Generates the ball position (x_pos, y_pos) for the 8x8 pong field.
- Feeds the paddle/matrix process stage.
- Consumes that stage's registered 8-bit paddle-neighbourhood vector (hit_vec) to decide paddle bounces versus misses.
- Runs the serve/rally/miss sequence and emits one-cycle miss pulses to the score logic.

Parameters:
- WIDTH, 8, field width/height in cells
- BIT_OF_WIDTH, 3, width of x_pos/y_pos
- X_MIN, 1, leftmost legal ball column
- X_MAX, 6, rightmost legal ball column
- SERVE_X, 3, serve column
- SERVE_Y, 3, serve row
- MISS_TICKS, 4, ticks the ball is held in the goal row before re-serve
- SLOW_DIV, 2, ticks per move before speed-up (BALL_SPEEDUP_EN only)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle move strobe; ticks are at least 3 clk apart
- start  input  1  one-cycle serve-launch request
- hit_vec  input  8  paddle neighbourhood: [2:0] = top paddle at x-1, x, x+1 when y_pos==1; [7:5] = bottom paddle at x-1, x, x+1 when y_pos==6; [4:3] unused
- x_pos  output  BIT_OF_WIDTH  ball column
- y_pos  output  BIT_OF_WIDTH  ball row, 0 = top goal, 7 = bottom goal
- dir_x  output  1  1 = moving right (+x), 0 = left
- dir_y  output  1  1 = moving down (+y), 0 = up
- top_miss  output  1  one-cycle pulse: top player missed
- down_miss  output  1  one-cycle pulse: bottom player missed
- busy  output  1  high in RUN and MISS

Behaviour:
- Reset (async, rst_n=0):
  - state=SERVE, x_pos=SERVE_X, y_pos=SERVE_Y, dir_x=1, dir_y=1.
  - top_miss=0, down_miss=0, busy=0, miss counter=0.
- All outputs are registered. Position updates one clk after the qualifying tick.
- Latency constraint: hit_vec is produced one clk after x_pos/y_pos change. The 3-clk tick spacing guarantees hit_vec is valid at the next tick. hit_vec is sampled only on tick.
- States:
  - SERVE: ball parked at SERVE_X/SERVE_Y, directions held. start -> RUN; tick is ignored.
  - RUN, on each tick:
    - Horizontal: nx = x + 1 if dir_x else x - 1. If the move would exceed X_MAX or go below X_MIN, reflect instead: dir_x toggles, nx = x - 1 or x + 1. x_pos stays within X_MIN..X_MAX at all times.
    - Vertical, moving up at y==1: hit = hit_vec[1] | (dir_x & hit_vec[2]) | (~dir_x & hit_vec[0]).
      - On hit: dir_y=1, y=2.
      - If only the corner bit caused the hit (hit_vec[1]=0), dir_x also toggles, and the horizontal move uses the new direction, with the same wall reflection rule.
      - No hit: y=0, pulse top_miss, go to MISS.
    - Vertical, moving down at y==6: symmetric using hit_vec[7:5] (centre = bit 6, right = bit 7, left = bit 5).
      - On hit: dir_y=0, y=5.
      - No hit: y=7, pulse down_miss, go to MISS.
    - Otherwise: y = y + 1 or y - 1.
  - MISS: ball frozen in the goal row. Counts MISS_TICKS ticks, then goes to SERVE with:
    - x=SERVE_X, y=SERVE_Y.
    - dir_y pointing toward the player who missed: up (0) after top_miss, down (1) after down_miss.
    - dir_x unchanged.
- start is ignored outside SERVE.
- start and tick in the same clk while in SERVE: state -> RUN only. The first move happens on the next tick.
- Miss pulses are exactly one clk wide, coincident with the position update to row 0 or row 7.
- Reset mid-rally returns to the reset state immediately; no miss pulse is emitted.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined:
  - A divider makes the ball move on every SLOW_DIV-th tick.
  - A 3-bit rally-hit counter increments on each paddle hit, saturating at 4. At 4, the ball moves on every tick.
  - Counter and divider clear in SERVE and on reset.
- Undefined: the ball moves on every tick in RUN; no counter or divider logic.

Test Plan:
- Reset, then start, then 3 ticks (dir 1/1) -> (x,y) = (4,4), (5,5), (6,6); top_miss = down_miss = 0.
- At (6,6) moving down-right, hit_vec=8'b0100_0000, tick -> dir_x=0, dir_y=0, (x,y)=(5,5).
- At (3,1) moving up-right, hit_vec=8'b0000_0100 (corner only), tick -> dir_y=1, dir_x=0, (x,y)=(2,2).
- At (4,6) moving down, hit_vec=0, tick -> y=7, down_miss high exactly 1 clk. After 4 more ticks -> SERVE at (3,3), dir_y=1, busy=0.
- Assert rst_n=0 at (5,2) mid-RUN -> outputs immediately (3,3), dir 1/1, busy=0; no miss pulse.
- With BALL_SPEEDUP_EN and SLOW_DIV=2: position changes every 2nd tick until the 4th paddle hit, then every tick.
